roulette_ctrl: RTL and testbench

ROULETTE_CTRL -- requirements
Module: roulette_ctrl

---
 rtl/roulette_pkg.sv | 24 ++
 rtl/roulette_edge_det.sv | 19 +
 rtl/roulette_ctrl.sv | 117 +++++++++++
 tb/tb_roulette_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/roulette_pkg.sv
// Shared types and constants for the roulette wheel controller: state encoding,
// wheel size, and the wrap-around position stepping helper.
package roulette_pkg;

  localparam int NUM_POS = 6;
  localparam int POS_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    DECEL  = 2'd2,
    RESULT = 2'd3
  } state_t;

  // One step around the wheel; the index never leaves 0..NUM_POS-1.
  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] pos,
                                                input logic             dir);
    if (dir)
      return (pos == '0) ? POS_W'(NUM_POS - 1) : pos - 1'b1;
    else
      return (pos == POS_W'(NUM_POS - 1)) ? '0 : pos + 1'b1;
  endfunction

endpackage

// File: rtl/roulette_edge_det.sv
// Registered rising-edge detector. The previous sample resets high so a level
// already asserted when reset releases is not mistaken for a fresh press.
module roulette_edge_det (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) prev <= 1'b1;
    else       prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/roulette_ctrl.sv
// Roulette wheel controller: spins a one-hot position, decelerates on stop and
// latches the final index. Define ROULETTE_CTRL_BLINK_EN to blink the display in RESULT.
module roulette_ctrl
  import roulette_pkg::*;
#(
  parameter logic [31:0] START_PERIOD = 32'd2_500_000,
  parameter logic [31:0] DECEL_STEP   = 32'd500_000,
  parameter logic [31:0] STOP_PERIOD  = 32'd12_500_000,
  parameter logic [31:0] BLINK_PERIOD = 32'd12_500_000
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  output logic [5:0]       seg,
  output logic [6:0]       ledout,
  output logic [POS_W-1:0] result,
  output logic             busy,
  output logic             done
);

  if (START_PERIOD == 32'd0 || BLINK_PERIOD == 32'd0) begin : g_param_check
    $error("roulette_ctrl: START_PERIOD and BLINK_PERIOD must be non-zero");
  end

  state_t           state;
  logic [POS_W-1:0] pos;
  logic [31:0]      period;
  logic [31:0]      tick;
  logic             start_rise;
  logic             stop_rise;
  logic             step;
  logic [32:0]      period_sum;
  logic [31:0]      period_next;
  logic [POS_W-1:0] pos_next;

  roulette_edge_det u_start_det (.clk(clk), .nrst(nrst), .din(start), .rise(start_rise));
  roulette_edge_det u_stop_det  (.clk(clk), .nrst(nrst), .din(stop),  .rise(stop_rise));

  assign busy        = (state == SPIN) || (state == DECEL);
  assign step        = busy && (tick == period - 32'd1);
  assign pos_next    = next_pos(pos, dir);
  assign period_sum  = {1'b0, period} + {1'b0, DECEL_STEP};
  assign period_next = period_sum[32] ? 32'hFFFF_FFFF : period_sum[31:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      pos    <= '0;
      period <= START_PERIOD;
      tick   <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, RESULT: begin
          if (start_rise) begin
            state  <= SPIN;
            period <= START_PERIOD;
            tick   <= '0;
          end
        end
        SPIN, DECEL: begin
          if (step) begin
            tick <= '0;
            pos  <= pos_next;
            if (state == DECEL) begin
              period <= period_next;
              if (period_next >= STOP_PERIOD) begin
                state  <= RESULT;
                result <= pos_next;
                done   <= 1'b1;
              end
            end
          end else begin
            tick <= tick + 32'd1;
          end
          // Stop keeps the running tick and period so the current step finishes on time.
          if (state == SPIN && stop_rise) state <= DECEL;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign seg = 6'b000001 << pos;

`ifdef ROULETTE_CTRL_BLINK_EN
  logic [31:0] blink_cnt;
  logic        blink_on;

  // The counter is parked outside RESULT so every entry starts with a full lit phase.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (state != RESULT) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_PERIOD - 32'd1) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  assign ledout = blink_on ? ~{1'b0, seg} : 7'b1111111;
`else
  assign ledout = ~{1'b0, seg};
`endif

endmodule

// File: tb/tb_roulette_ctrl.sv
// Bench for roulette_ctrl: directed scenarios plus random button traffic, all
// compared each cycle against a countdown-based behavioural model of the wheel.
module tb_roulette_ctrl;

  localparam int START = 4;
  localparam int DSTEP = 2;
  localparam int STOPP = 10;
  localparam int BLINK = 3;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b0;
  logic [5:0] seg;
  logic [6:0] ledout;
  logic [2:0] result;
  logic       busy;
  logic       done;

  roulette_ctrl #(
    .START_PERIOD(32'(START)),
    .DECEL_STEP  (32'(DSTEP)),
    .STOP_PERIOD (32'(STOPP)),
    .BLINK_PERIOD(32'(BLINK))
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .stop(stop), .dir(dir),
    .seg(seg), .ledout(ledout), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 spinning, 2 slowing, 3 halted; 'left' counts cycles to the next step.
  int     m_mode, m_pos, m_left, m_res, m_rcyc;
  longint m_per;
  bit     m_done, m_ps, m_pt;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_left = START; m_res = 0; m_rcyc = 0;
    m_per = START; m_done = 0; m_ps = 1; m_pt = 1;
  endtask

  task automatic model_step(input bit s, input bit t, input bit d);
    bit se, te;
    se = s && !m_ps;
    te = t && !m_pt;
    m_ps = s; m_pt = t;
    m_done = 0;
    if (m_mode == 0 || m_mode == 3) begin
      if (m_mode == 3) m_rcyc++;
      if (se) begin
        m_mode = 1; m_per = START; m_left = START;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_pos = d ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
        if (m_mode == 2) begin
          m_per = m_per + DSTEP;
          if (m_per > 64'hFFFF_FFFF) m_per = 64'hFFFF_FFFF;
          if (m_per >= STOPP) begin
            m_mode = 3; m_res = m_pos; m_done = 1; m_rcyc = 0;
          end
        end
        m_left = int'(m_per);
      end
      if (m_mode == 1 && te) m_mode = 2;
    end
  endtask

  task automatic check_outputs();
    logic [5:0] e_seg;
    logic [6:0] e_led;
    bit         lit;
    e_seg = 6'(1 << m_pos);
    lit = 1;
`ifdef ROULETTE_CTRL_BLINK_EN
    if (m_mode == 3) lit = ((m_rcyc / BLINK) % 2) == 0;
`endif
    e_led = lit ? {1'b1, ~e_seg} : 7'b1111111;
    check("seg", 32'(seg), 32'(e_seg));
    check("ledout", 32'(ledout), 32'(e_led));
    check("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
    check("done", 32'(done), 32'(m_done));
    check("result", 32'(result), 32'(m_res));
  endtask

  // One clock: drive inputs (called just after a falling edge), step model, check.
  task automatic cycle(input bit s, input bit t, input bit d);
    start = s; stop = t; dir = d;
    @(posedge clk);
    model_step(s, t, d);
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock.
  task automatic async_reset(input bit hold_start);
    #2;
    nrst = 1'b0;
    start = hold_start; stop = 1'b0;
    #1;
    model_reset();
    check("rst_seg", 32'(seg), 32'h01);
    check("rst_ledout", 32'(ledout), 32'h7E);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    check_outputs();
    nrst = 1'b1;
  endtask

  int dones;

  initial begin
    model_reset();
    @(negedge clk);
    check_outputs();
    check("reset_ledout", 32'(ledout), 32'h7E);
    nrst = 1'b1;

    // Forward spin through a full revolution.
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 26; i++) cycle(1, 0, 0);

    // Stop at index 2 and watch deceleration to the final index.
    for (int i = 0; i < 40 && m_pos != 2; i++) cycle(0, 0, 0);
    cycle(0, 1, 0);
    dones = 0;
    for (int i = 0; i < 40 && m_mode != 3; i++) begin
      cycle(0, 0, 0);
      dones += int'(done);
    end
    check("decel_result", 32'(result), 32'd5);
    check("decel_seg", 32'(seg), 32'h20);
    check("decel_busy", 32'(busy), 32'd0);
    check("decel_done_cnt", 32'(dones), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0);
      dones += int'(done);
    end
    check("done_once", 32'(dones), 32'd1);

    // Stop alone in IDLE is ignored; simultaneous start+stop enters SPIN only.
    async_reset(0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    check("stop_idle_busy", 32'(busy), 32'd0);
    cycle(1, 1, 0);
    for (int i = 0; i < 40; i++) cycle(0, 0, 0);
    check("start_stop_spin", 32'(busy), 32'd1);

    // Reset mid-decel with start held through release: remain idle.
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    async_reset(1);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);
    check("held_start_idle", 32'(busy), 32'd0);

    // Backward from index 0 wraps to 5 on the first step.
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1);
    check("wrap_back", 32'(seg), 32'h20);

    // Random button traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset(bit'($urandom_range(0, 1)));
      else cycle($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
